alu_seq_ctrl: RTL

//  Multi-cycle fetch/decode/execute controller that sequences the 8-bit ALU and register file.

---
 rtl/alu_seq_pkg.sv | 56 +++++
 rtl/alu_seq_decode.sv | 74 +++++++
 rtl/alu_seq_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencing controller: opcodes, FSM states,
// write-back source selects, instruction field bounds and the decode class.
package alu_seq_pkg;

    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 9;
    localparam int RS_HI   = 8;
    localparam int RS_LO   = 6;
    localparam int OFF6_HI = 5;
    localparam int IMM8_HI = 7;
    localparam int SH_HI   = 2;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_OUT  = 4'h2;
    localparam logic [3:0] OP_SLT  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_SUBI = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_IN   = 4'h8;
    localparam logic [3:0] OP_XORI = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
    localparam logic [3:0] OP_BNZ  = 4'hC;
    localparam logic [3:0] OP_ST   = 4'hD;
    localparam logic [3:0] OP_MOV  = 4'hE;
    localparam logic [3:0] OP_JMP  = 4'hF;

    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_MEM = 2'd1;
    localparam logic [1:0] WSEL_IN  = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP = 4'd0,
        CL_ALU = 4'd1,
        CL_IN  = 4'd2,
        CL_OUT = 4'd3,
        CL_BZ  = 4'd4,
        CL_BNZ = 4'd5,
        CL_JMP = 4'd6,
        CL_LD  = 4'd7,
        CL_ST  = 4'd8
    } op_class_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder: maps the 4-bit op field to ALU controls,
// write-back behaviour and the instruction class used by the sequencer.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] i_op,
    output logic [3:0] o_alu_fs,
    output logic       o_alu_bsel,
    output logic       o_wb_en,
    output logic [1:0] o_wsel,
    output logic       o_flag_en,
    output logic       o_ra_rd,
    output op_class_t  o_class
);

    always_comb begin
        o_alu_fs   = i_op;
        o_alu_bsel = 1'b0;
        o_wb_en    = 1'b0;
        o_wsel     = WSEL_ALU;
        o_flag_en  = 1'b0;
        o_ra_rd    = 1'b0;
        o_class    = CL_NOP;
        case (i_op)
            OP_ADD, OP_SLT, OP_AND, OP_SLL, OP_MOV: begin
                o_wb_en   = 1'b1;
                o_flag_en = 1'b1;
                o_class   = CL_ALU;
                if (i_op == OP_MOV) o_alu_fs = 4'h2;
            end
            OP_SUBI, OP_XORI, OP_ADDI: begin
                o_alu_bsel = 1'b1;
                o_wb_en    = 1'b1;
                o_flag_en  = 1'b1;
                o_class    = CL_ALU;
            end
            OP_IN: begin
                o_wb_en = 1'b1;
                o_wsel  = WSEL_IN;
                o_class = CL_IN;
            end
            OP_OUT: begin
                o_ra_rd = 1'b1;
                o_class = CL_OUT;
            end
            // LD write-back happens in MEM on the ack cycle, not in EXEC
            OP_LD: begin
                o_alu_bsel = 1'b1;
                o_wsel     = WSEL_MEM;
                o_class    = CL_LD;
            end
            OP_ST: begin
                o_alu_fs   = 4'h5;
                o_alu_bsel = 1'b1;
                o_ra_rd    = 1'b1;
                o_class    = CL_ST;
            end
            OP_BZ, OP_BNZ: begin
                o_alu_fs = 4'h5;
                o_ra_rd  = 1'b1;
                o_class  = (i_op == OP_BZ) ? CL_BZ : CL_BNZ;
            end
            OP_JMP: begin
                o_alu_fs = 4'h0;
                o_class  = CL_JMP;
            end
            default: begin
                o_alu_fs = 4'h0;
                o_class  = CL_NOP;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit ALU datapath:
// fetches instructions, drives ALU/register-file controls, data memory and branches.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IR_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IR_W-1:0] imem_data,
    output logic [2:0]      rf_ra,
    output logic [2:0]      rf_rb,
    output logic [2:0]      rf_wa,
    output logic            rf_we,
    output logic [1:0]      rf_wsel,
    output logic [3:0]      alu_fs,
    output logic [2:0]      alu_sh,
    output logic            alu_bsel,
    output logic [7:0]      imm,
    input  logic            alu_z,
    input  logic            alu_n,
    input  logic            alu_c,
    input  logic            alu_v,
    output logic [3:0]      flags,
    output logic            dmem_re,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            out_we,
    output logic            halted
);

    state_t          r_state, w_state_next;
    logic [PC_W-1:0] r_pc, w_pc_next;
    logic [IR_W-1:0] r_ir, w_ir_next;
    logic [3:0]      r_flags, w_flags_next;

    logic [3:0]      w_alu_fs;
    logic            w_alu_bsel;
    logic            w_wb_en;
    logic [1:0]      w_wsel;
    logic            w_flag_en;
    logic            w_ra_rd;
    op_class_t       w_class;

    logic            w_active;
    logic [2:0]      w_rd, w_rs;
    logic [PC_W-1:0] w_br_off;
    logic [PC_W-1:0] w_jmp_tgt;

    alu_seq_decode u_decode (
        .i_op       (r_ir[OP_HI:OP_LO]),
        .o_alu_fs   (w_alu_fs),
        .o_alu_bsel (w_alu_bsel),
        .o_wb_en    (w_wb_en),
        .o_wsel     (w_wsel),
        .o_flag_en  (w_flag_en),
        .o_ra_rd    (w_ra_rd),
        .o_class    (w_class)
    );

    assign w_rd      = r_ir[RD_HI:RD_LO];
    assign w_rs      = r_ir[RS_HI:RS_LO];
    assign w_br_off  = {{(PC_W-6){r_ir[OFF6_HI]}}, r_ir[OFF6_HI:0]};
    assign w_jmp_tgt = PC_W'(r_ir[IMM8_HI:0]);

    // Decoded controls are only presented while an instruction is in flight
    assign w_active  = (r_state == ST_DECODE) || (r_state == ST_EXEC) || (r_state == ST_MEM);
    assign rf_ra     = w_active ? (w_ra_rd ? w_rd : w_rs) : 3'd0;
    assign rf_rb     = w_active ? w_rs : 3'd0;
    assign rf_wa     = w_active ? w_rd : 3'd0;
    assign alu_fs    = w_active ? w_alu_fs : 4'd0;
    assign alu_bsel  = w_active ? w_alu_bsel : 1'b0;
    assign alu_sh    = w_active ? r_ir[SH_HI:0] : 3'd0;
    assign imm       = w_active ? {{2{r_ir[OFF6_HI]}}, r_ir[OFF6_HI:0]} : 8'd0;
    assign imem_addr = r_pc;
    assign flags     = r_flags;
    assign halted    = (r_state == ST_HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
            r_flags <= w_flags_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        w_flags_next = r_flags;
        imem_req     = 1'b0;
        rf_we        = 1'b0;
        rf_wsel      = WSEL_ALU;
        out_we       = 1'b0;
        dmem_re      = 1'b0;
        dmem_we      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_ir_next    = imem_data;
                    w_pc_next    = r_pc + 1'b1;
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: w_state_next = ST_EXEC;
            ST_EXEC: begin
                w_state_next = ST_FETCH;
                if (w_wb_en) begin
                    rf_we   = 1'b1;
                    rf_wsel = w_wsel;
                end
                if (w_flag_en) w_flags_next = {alu_n, alu_z, alu_c, alu_v};
                case (w_class)
                    CL_OUT: out_we = 1'b1;
                    CL_BZ:  if (alu_z)  w_pc_next = r_pc + w_br_off;
                    CL_BNZ: if (!alu_z) w_pc_next = r_pc + w_br_off;
                    // r_pc already points past the JMP, so a self-jump targets r_pc-1
                    CL_JMP: begin
                        if (w_jmp_tgt == r_pc - 1'b1) w_state_next = ST_HALT;
                        else                          w_pc_next    = w_jmp_tgt;
                    end
                    CL_LD, CL_ST: w_state_next = ST_MEM;
                    default: ;
                endcase
            end
            ST_MEM: begin
                dmem_re = (w_class == CL_LD);
                dmem_we = (w_class == CL_ST);
                if (dmem_ack) begin
                    w_state_next = ST_FETCH;
                    if (w_class == CL_LD) begin
                        rf_we   = 1'b1;
                        rf_wsel = w_wsel;
                    end
                end
            end
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_FETCH;
        endcase
    end

endmodule
